// File: rtl/hack_pkg.sv
// Shared constants for the Hack CPU datapath: word width and mux select encoding.
package hack_pkg;
    localparam int   HACK_WORD_W = 16;
    localparam logic SEL_A       = 1'b0;
    localparam logic SEL_B       = 1'b1;
endpackage

// File: rtl/mux.sv
// 2-to-1 selector leaf cell: combinational output plus a one-cycle registered copy.
module mux
    import hack_pkg::*;
#(
    parameter int          WIDTH     = 1,
    parameter logic [63:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q
);

    // The conditional operator merges a and b bitwise when sel is X/Z,
    // so agreeing bits stay known in simulation.
    assign out = (sel == SEL_B) ? b : a;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_q <= RESET_VAL[WIDTH-1:0];
        else        out_q <= out;
    end

endmodule

// File: tb/tb_mux.sv
// Directed bench for mux: truth table, reset behaviour, wide data and select glitches.
module tb_mux;

    logic        clk;
    logic        rst_n;
    logic        a1, b1, sel1;
    logic        out1, out1_q;
    logic [15:0] a16, b16;
    logic        sel16;
    logic [15:0] out16, out16_q;
    logic [15:0] out16f, out16f_q;

    int checks = 0;
    int errors = 0;

    mux #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .sel(sel1),
        .out(out1), .out_q(out1_q)
    );

    mux #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .sel(sel16),
        .out(out16), .out_q(out16_q)
    );

    mux #(.WIDTH(16), .RESET_VAL(64'hFFFF)) u_w16f (
        .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .sel(sel16),
        .out(out16f), .out_q(out16f_q)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out1_q !== 1'b0) begin
            errors++; $display("FAIL reset_w1 out_q=%b expected=%b", out1_q, 1'b0);
        end
        checks++;
        if (out16_q !== 16'h0000) begin
            errors++; $display("FAIL reset_w16 out_q=%h expected=%h", out16_q, 16'h0000);
        end
        checks++;
        if (out16f_q !== 16'hFFFF) begin
            errors++; $display("FAIL reset_w16f out_q=%h expected=%h", out16f_q, 16'hFFFF);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_truth_table();
        logic [7:0] exp_tab;
        logic       prev;
        exp_tab = 8'b1101_1000; // index i -> bit i: 0,0,0,1,1,0,1,1
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            {a1, b1, sel1} = i[2:0];
            prev = out1_q;
            #1;
            checks++;
            if (out1 !== exp_tab[i]) begin
                errors++; $display("FAIL tt_out[%0d] out=%b expected=%b", i, out1, exp_tab[i]);
            end
            // Registered copy must not move before the edge
            if (i > 0) begin
                checks++;
                if (out1_q !== exp_tab[i-1]) begin
                    errors++; $display("FAIL tt_hold[%0d] out_q=%b expected=%b", i, out1_q, exp_tab[i-1]);
                end
            end
            @(posedge clk); #1;
            checks++;
            if (out1_q !== exp_tab[i]) begin
                errors++; $display("FAIL tt_out_q[%0d] out_q=%b expected=%b", i, out1_q, exp_tab[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        {a1, b1, sel1} = 3'b111;
        @(posedge clk); #1;
        checks++;
        if (out1_q !== 1'b1) begin
            errors++; $display("FAIL ar_pre out_q=%b expected=%b", out1_q, 1'b1);
        end
        #4 rst_n = 1'b0;
        #1;
        checks++;
        if (out1_q !== 1'b0) begin
            errors++; $display("FAIL ar_async out_q=%b expected=%b", out1_q, 1'b0);
        end
        checks++;
        if (out1 !== 1'b1) begin
            errors++; $display("FAIL ar_out out=%b expected=%b", out1, 1'b1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (out1_q !== 1'b0) begin
            errors++; $display("FAIL ar_release_hold out_q=%b expected=%b", out1_q, 1'b0);
        end
        @(posedge clk); #1;
        checks++;
        if (out1_q !== 1'b1) begin
            errors++; $display("FAIL ar_first_edge out_q=%b expected=%b", out1_q, 1'b1);
        end
    endtask

    task automatic test_wide();
        @(negedge clk);
        a16 = 16'h1234; b16 = 16'hABCD; sel16 = 1'b0;
        #1;
        checks++;
        if (out16 !== 16'h1234) begin
            errors++; $display("FAIL wide_sel0 out=%h expected=%h", out16, 16'h1234);
        end
        @(posedge clk); #1;
        checks++;
        if (out16_q !== 16'h1234) begin
            errors++; $display("FAIL wide_sel0_q out_q=%h expected=%h", out16_q, 16'h1234);
        end
        @(negedge clk);
        sel16 = 1'b1;
        #1;
        checks++;
        if (out16 !== 16'hABCD) begin
            errors++; $display("FAIL wide_sel1 out=%h expected=%h", out16, 16'hABCD);
        end
        checks++;
        if (out16_q !== 16'h1234) begin
            errors++; $display("FAIL wide_sel1_hold out_q=%h expected=%h", out16_q, 16'h1234);
        end
        @(posedge clk); #1;
        checks++;
        if (out16_q !== 16'hABCD) begin
            errors++; $display("FAIL wide_sel1_q out_q=%h expected=%h", out16_q, 16'hABCD);
        end
        checks++;
        if (out16f_q !== 16'hABCD) begin
            errors++; $display("FAIL wide_f_q out_q=%h expected=%h", out16f_q, 16'hABCD);
        end
    endtask

    task automatic test_glitch();
        @(negedge clk);
        a1 = 1'b0; b1 = 1'b1; sel1 = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (out1_q !== 1'b0) begin
            errors++; $display("FAIL gl_pre out_q=%b expected=%b", out1_q, 1'b0);
        end
        @(negedge clk);
        sel1 = 1'b1;
        #1;
        checks++;
        if (out1 !== 1'b1) begin
            errors++; $display("FAIL gl_pulse out=%b expected=%b", out1, 1'b1);
        end
        #2 sel1 = 1'b0;
        #1;
        checks++;
        if (out1 !== 1'b0) begin
            errors++; $display("FAIL gl_return out=%b expected=%b", out1, 1'b0);
        end
        @(posedge clk); #1;
        checks++;
        if (out1_q !== 1'b0) begin
            errors++; $display("FAIL gl_out_q out_q=%b expected=%b", out1_q, 1'b0);
        end
    endtask

    task automatic test_reset_hold();
        logic [15:0] av [4];
        logic [15:0] bv [4];
        logic        sv [4];
        logic [15:0] ev [4];
        av = '{16'h0001, 16'h5A5A, 16'hFFFF, 16'h8000};
        bv = '{16'h0002, 16'hA5A5, 16'h0000, 16'h7FFF};
        sv = '{1'b1, 1'b0, 1'b1, 1'b0};
        ev = '{16'h0002, 16'h5A5A, 16'h0000, 16'h8000};
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a16 = av[i]; b16 = bv[i]; sel16 = sv[i];
            #1;
            checks++;
            if (out16f !== ev[i]) begin
                errors++; $display("FAIL rh_out[%0d] out=%h expected=%h", i, out16f, ev[i]);
            end
            @(posedge clk); #1;
            checks++;
            if (out16f_q !== 16'hFFFF) begin
                errors++; $display("FAIL rh_f_q[%0d] out_q=%h expected=%h", i, out16f_q, 16'hFFFF);
            end
            checks++;
            if (out16_q !== 16'h0000) begin
                errors++; $display("FAIL rh_z_q[%0d] out_q=%h expected=%h", i, out16_q, 16'h0000);
            end
        end
        @(negedge clk);
        rst_n = 1'b1; sel16 = 1'b0; a16 = 16'h0000;
        @(posedge clk); #1;
        checks++;
        if (out16f_q !== 16'h0000) begin
            errors++; $display("FAIL rh_release out_q=%h expected=%h", out16f_q, 16'h0000);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        a1 = 1'b0; b1 = 1'b0; sel1 = 1'b0;
        a16 = '0; b16 = '0; sel16 = 1'b0;
        test_reset();
        test_truth_table();
        test_async_reset();
        test_wide();
        test_glitch();
        test_reset_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
